uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered 8N1 UART transmitter: the transmit end of the SoC's host serial link, driving the board's `uart0_tx` pin toward the host terminal. It accepts bytes on a valid/ready stream from the SoC bus-side register logic, queues them in a small FIFO and serialises them back-to-back at a fixed baud rate derived from the Wishbone clock. It pairs with the existing UART receive path and shares its baud arithmetic.

## Interface
- `CLOCK_FREQUENCY`, default 24000000: input clock in Hz (the `wb_clk` rate).
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 16: byte capacity; must be a power of two, at least 2.

- `clock` in 1: single clock. All logic is clocked on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_i` in 8: byte to send.
- `valid_i` in 1: `data_i` is valid.
- `ready_o` out 1: FIFO can accept a byte. A push happens when `valid_i && ready_o`.
- `tx_o` out 1: serial line. Idle level is high.
- `busy_o` out 1: asserted while the FIFO is non-empty or a frame is in progress.
- `level_o` out $clog2(FIFO_DEPTH)+1: bytes currently queued, excluding the byte being shifted.

## Operation
- DIV = (CLOCK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE, computed at elaboration. This gives 208 at the default values, about 0.16% error.
- Elaboration fails if DIV < 4.
- Frame format: start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit lasts exactly DIV cycles.
- FIFO behaviour:
  - `ready_o = !full`. The value does not depend on a same-cycle pop.
  - On a simultaneous push and pop, `level_o` is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Serialiser FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx_o`=0 for DIV cycles, then go to DATA.
  - DATA: `tx_o`=shift[0]. Every DIV cycles, shift right and increment the bit index. After the 8th bit's DIV cycles, go to STOP.
  - STOP: `tx_o`=1 for DIV cycles. On the final cycle:
    - If the FIFO is non-empty, pop and go directly to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- The baud counter runs from 0 to DIV-1 and wraps to 0 at each bit boundary.
- `valid_i` while `ready_o`=0 is ignored. The byte is not latched, and the producer must hold it.
- Reset mid-frame aborts the frame immediately: `tx_o` returns high and FIFO contents are discarded. The host sees a truncated frame, which is acceptable.

## Timing
- Reset values: `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0, state IDLE, counters 0.
- `tx_o` is driven from a flop and never glitches.
- Latency with an empty FIFO in IDLE, push at edge N:
  - `level_o`=1 and `busy_o`=1 after edge N.
  - The pop happens at edge N+1, making `level_o`=0.
  - `tx_o` falls after edge N+2.
- Frame duration is 10*DIV cycles: the start-bit falling edge to the next start-bit falling edge for back-to-back bytes.
- `busy_o` deasserts on the edge where STOP ends with the FIFO empty.
- `level_o` and `ready_o` update on the edge after the push or pop.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - The DIV rounding function, also used by the receive path.
  - The 8N1 constants DATA_BITS=8 and STOP_BITS=1.
- Sub-module `sync_fifo`, parameterised by WIDTH and DEPTH. It provides push/pop, full/empty and level, with first-word-fall-through read data. The serialiser FSM, baud counter and shift register stay in `uart_tx_fifo`.

## Test plan
- Single byte: with DIV=208, push 0x55. `tx_o` falls 2 cycles after the push. The bench samples mid-bit and reads start=0, bits 1,0,1,0,1,0,1,0, stop=1. `busy_o` drops 2080 cycles after the fall.
- Back-to-back: push 0x00, 0xFF, 0xA5 on consecutive cycles. The three frames decode in order with no idle cycles between a stop bit and the next start bit. The total busy span is 3*2080 cycles.
- Full FIFO: with DEPTH=4, push 6 bytes while the first is being shifted. `ready_o` drops after 5 accepted pushes (1 in the shifter plus 4 queued) and `level_o`=4. Held `valid_i` succeeds one cycle after the next pop, and all bytes arrive intact.
- Simultaneous push/pop: push on the STOP→START pop cycle with `level_o`=2. `level_o` stays 2 and byte order is preserved.
- Reset mid-frame: assert `reset` for 1 cycle during DATA bit 4 with 3 bytes queued. The next cycle shows `tx_o`=1, `level_o`=0, `busy_o`=0 and `ready_o`=1. A new push of 0x3C then transmits correctly.
- Parameters: CLOCK_FREQUENCY=50000000, BAUD_RATE=115200 gives DIV=434, measured on the start-bit width.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive paths: 8N1 framing
// constants, serialiser state encoding and the baud divisor arithmetic.
package uart_pkg;

  // 8N1 framing.
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  // Serialiser state encoding, kept as plain constants so older tools and the
  // receive path can share the same values.
  typedef logic [1:0] uart_state_t;

  localparam uart_state_t StIdle  = 2'd0;
  localparam uart_state_t StStart = 2'd1;
  localparam uart_state_t StData  = 2'd2;
  localparam uart_state_t StStop  = 2'd3;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. Pointers carry one
// extra wrap bit so that full and empty can be told apart without a counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             push_en;
  logic             pop_en;

  // Pushes into a full FIFO and pops from an empty one are dropped here so the
  // pointers can never cross.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // Pointer next-state: advance on accepted push/pop, wrapping naturally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_en) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_en) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Pointer registers; reset empties the FIFO without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage write; contents are don't-care until the write pointer passes them.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter. Bytes arrive on a valid/ready stream, are
// queued in a sync_fifo and serialised back-to-back at CLOCK_FREQUENCY /
// BAUD_RATE cycles per bit. The line output is registered so it never glitches.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 24000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned Div  = baud_div(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned CntW = $clog2(Div);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] DivMax   = CntW'(Div - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  if (Div < 4) begin : gen_div_check
    $error("uart_tx_fifo: CLOCK_FREQUENCY / BAUD_RATE must be at least 4");
  end

  // FIFO interface.
  logic                        fifo_push;
  logic                        fifo_pop;
  logic [7:0]                  fifo_rdata;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  // Serialiser state.
  uart_state_t          state_q, state_d;
  logic [CntW-1:0]      baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 line_busy_q, line_busy_d;
  logic                 bit_end;

  assign fifo_push = valid_i && !fifo_full;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (data_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bit_end = (baud_cnt_q == DivMax);

  // Serialiser next-state: baud counting, bit sequencing and FIFO pops.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;

    if (state_q != StIdle) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_rdata;
          bit_idx_d  = '0;
          baud_cnt_d = '0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LastData) begin
            bit_idx_d = '0;
            state_d   = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (bit_idx_q != LastStop) begin
            bit_idx_d = bit_idx_q + 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next frame: no idle bit between frames.
            fifo_pop  = 1'b1;
            shift_d   = fifo_rdata;
            bit_idx_d = '0;
            state_d   = StStart;
          end else begin
            bit_idx_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line level decoded from the current state; registered one cycle later so
  // every bit still lasts exactly Div cycles on the wire.
  always_comb begin
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    // Tracks the registered line so busy covers the last stop bit on the wire.
    line_busy_d = (state_q != StIdle);
  end

  // Serialiser registers; reset aborts any frame and forces the line idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      line_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      line_busy_q <= line_busy_d;
    end
  end

  assign ready_o = !fifo_full;
  assign tx_o    = tx_q;
  assign level_o = fifo_level;
  assign busy_o  = !fifo_empty || (state_q != StIdle) || line_busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a line monitor decodes every frame mid-bit and checks
// it against a queue of accepted bytes; scenario tasks check timing and levels.
module tb_uart_tx_fifo;

  localparam int Div   = 208;        // (24 MHz + 57600) / 115200
  localparam int Frame = 10 * Div;
  localparam int Div2  = 434;        // (50 MHz + 57600) / 115200

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o, tx_o, busy_o;
  logic [2:0] level_o;

  logic [7:0] data_b = 8'h00;
  logic       valid_b = 1'b0;
  logic       ready_b, tx_b, busy_b;
  logic [2:0] level_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] exp_q [$];
  int         falls [$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (24000000),
    .BAUD_RATE       (115200),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .level_o (level_o)
  );

  uart_tx_fifo #(
    .CLOCK_FREQUENCY (50000000),
    .BAUD_RATE       (115200),
    .FIFO_DEPTH      (4)
  ) dut_b (
    .clock   (clock),
    .reset   (reset),
    .data_i  (data_b),
    .valid_i (valid_b),
    .ready_o (ready_b),
    .tx_o    (tx_b),
    .busy_o  (busy_b),
    .level_o (level_b)
  );

  // Line monitor: detects start edges, samples each bit in its middle and
  // compares the decoded byte with the oldest accepted byte.
  initial begin
    logic       act;
    logic       prev_tx;
    int         cnt;
    int         k;
    logic [7:0] got;
    logic [7:0] want;
    act = 1'b0;
    prev_tx = 1'b1;
    cnt = 0;
    got = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        act = 1'b0;
      end else if (!act && prev_tx === 1'b1 && tx_o === 1'b0) begin
        act = 1'b1;
        cnt = 0;
        falls.push_back(cyc);
      end
      if (act && !reset) begin
        if (cnt == Div / 2) begin
          n_cmp++;
          if (tx_o !== 1'b0) begin
            n_err++;
            $display("FAIL start_bit: line %b mid start bit, required 0", tx_o);
          end
        end else if (cnt > Div / 2 && (cnt - Div / 2) % Div == 0) begin
          k = (cnt - Div / 2) / Div;
          if (k <= 8) begin
            got[k-1] = tx_o;
          end else begin
            n_cmp++;
            if (tx_o !== 1'b1) begin
              n_err++;
              $display("FAIL stop_bit: line %b mid stop bit, required 1", tx_o);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL frame_extra: decoded %02h, required no frame", got);
            end else begin
              want = exp_q.pop_front();
              if (got !== want) begin
                n_err++;
                $display("FAIL frame_data: decoded %02h, required %02h", got, want);
              end
            end
            act = 1'b0;
          end
        end
        cnt++;
      end
      prev_tx = tx_o;
    end
  end

  // Offer one byte and hold valid until it is accepted; returns the accept edge.
  task automatic push(input logic [7:0] b, output int acc);
    bit ok;
    ok = 1'b0;
    data_i  = b;
    valid_i = 1'b1;
    for (int i = 0; i < 20000 && !ok; i++) begin
      ok = ready_o;
      @(posedge clock); #1;
    end
    valid_i = 1'b0;
    acc = cyc;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL push_timeout: byte %02h not accepted, required acceptance", b);
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (busy_o === 1'b0) begin
        at = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    n_cmp++;
    if (at < 0) begin
      n_err++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy_o, budget);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drained: %0d bytes never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({tx_o, ready_o, busy_o, level_o} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state: tx/ready/busy/level %b/%b/%b/%0d, required 1/1/0/0",
               tx_o, ready_o, busy_o, level_o);
    end
    n_cmp++;
    if ({tx_b, ready_b, busy_b, level_b} !== {1'b1, 1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL reset_state_b: tx/ready/busy/level %b/%b/%b/%0d, required 1/1/0/0",
               tx_b, ready_b, busy_b, level_b);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int n, t;
    falls.delete();
    push(8'h55, n);
    n_cmp++;
    if (level_o !== 3'd1 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL single_push: level %0d busy %b, required 1 and 1", level_o, busy_o);
    end
    @(posedge clock); #1;
    n_cmp++;
    if (level_o !== 3'd0) begin
      n_err++;
      $display("FAIL single_pop: level %0d, required 0", level_o);
    end
    wait_idle(3 * Frame, t);
    n_cmp++;
    if (falls.size() != 1) begin
      n_err++;
      $display("FAIL single_falls: %0d start edges, required 1", falls.size());
    end else begin
      n_cmp++;
      if (falls[0] - n != 2) begin
        n_err++;
        $display("FAIL single_latency: tx fell %0d cycles after push, required 2", falls[0] - n);
      end
      n_cmp++;
      if (t - falls[0] != Frame) begin
        n_err++;
        $display("FAIL single_busy: busy dropped %0d cycles after fall, required %0d",
                 t - falls[0], Frame);
      end
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    int n, t;
    falls.delete();
    push(8'h00, n);
    push(8'hFF, n);
    push(8'hA5, n);
    wait_idle(5 * Frame, t);
    n_cmp++;
    if (falls.size() != 3) begin
      n_err++;
      $display("FAIL b2b_falls: %0d start edges, required 3", falls.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (falls[i] - falls[i-1] != Frame) begin
          n_err++;
          $display("FAIL b2b_gap: frame %0d started %0d cycles after previous, required %0d",
                   i, falls[i] - falls[i-1], Frame);
        end
      end
      n_cmp++;
      if (t - falls[0] != 3 * Frame) begin
        n_err++;
        $display("FAIL b2b_span: busy span %0d, required %0d", t - falls[0], 3 * Frame);
      end
    end
    check_drained("b2b");
  endtask

  task automatic test_full();
    logic [7:0] bytes [6];
    int n0, n, t;
    bytes = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h5A, 8'hE7};
    push(bytes[0], n0);
    for (int i = 1; i < 5; i++) push(bytes[i], n);
    n_cmp++;
    if (ready_o !== 1'b0 || level_o !== 3'd4) begin
      n_err++;
      $display("FAIL full_state: ready %b level %0d, required 0 and 4", ready_o, level_o);
    end
    push(bytes[5], n);
    n_cmp++;
    if (n - n0 != Frame + 2) begin
      n_err++;
      $display("FAIL full_held: accepted %0d cycles after first push, required %0d",
               n - n0, Frame + 2);
    end
    n_cmp++;
    if (level_o !== 3'd4) begin
      n_err++;
      $display("FAIL full_refill: level %0d, required 4", level_o);
    end
    wait_idle(8 * Frame, t);
    check_drained("full");
  endtask

  task automatic test_simultaneous();
    int n0, n, t;
    push(8'h12, n0);
    push(8'h34, n);
    push(8'h56, n);
    wait_until(n0 + Frame);
    n_cmp++;
    if (level_o !== 3'd2) begin
      n_err++;
      $display("FAIL simul_before: level %0d, required 2", level_o);
    end
    push(8'h96, n);
    n_cmp++;
    if (n != n0 + Frame + 1 || level_o !== 3'd2) begin
      n_err++;
      $display("FAIL simul_level: accept offset %0d level %0d, required %0d and 2",
               n - n0, level_o, Frame + 1);
    end
    wait_idle(6 * Frame, t);
    check_drained("simul");
  endtask

  task automatic test_reset_mid();
    int n0, n, t;
    push(8'hA1, n0);
    push(8'hB2, n);
    push(8'hC3, n);
    push(8'hD4, n);
    n_cmp++;
    if (level_o !== 3'd3) begin
      n_err++;
      $display("FAIL rstmid_queued: level %0d, required 3", level_o);
    end
    // Middle of data bit 4 of the first frame.
    wait_until(n0 + 1 + 5 * Div + Div / 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    n_cmp++;
    if ({tx_o, level_o, busy_o, ready_o} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rstmid_state: tx/level/busy/ready %b/%0d/%b/%b, required 1/0/0/1",
               tx_o, level_o, busy_o, ready_o);
    end
    repeat (5) begin
      @(posedge clock); #1;
    end
    push(8'h3C, n);
    wait_idle(3 * Frame, t);
    check_drained("rstmid");
  endtask

  task automatic test_div434();
    int w;
    bit seen;
    data_b  = 8'hFF;
    valid_b = 1'b1;
    @(posedge clock); #1;
    valid_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clock); #1;
      seen = (tx_b === 1'b0);
    end
    w = 0;
    while (seen && tx_b === 1'b0 && w < 2000) begin
      w++;
      @(posedge clock); #1;
    end
    n_cmp++;
    if (w != Div2) begin
      n_err++;
      $display("FAIL div434_start: start bit %0d cycles wide, required %0d", w, Div2);
    end
    for (int i = 0; i < 12 * Div2 && busy_b !== 1'b0; i++) begin
      @(posedge clock); #1;
    end
    n_cmp++;
    if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
      n_err++;
      $display("FAIL div434_idle: busy %b tx %b, required 0 and 1", busy_b, tx_b);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_div434();
    repeat (5) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
